// File: rtl/toggle_hs_rx.sv
// Receiver for a two-phase (toggle) req/ack link: synchronises req_t, captures data_in into a 2-entry FIFO, answers on ack_t.
// Optional word parity checking is enabled by defining TOGGLE_HS_RX_PARITY_EN.
module toggle_hs_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_t,
    input  logic [DATA_W-1:0] data_in,
    input  logic              par_in,
    output logic              ack_t,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              par_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_seen;
    logic                   r_ack_t;
    logic [CNT_W-1:0]       r_xfer_cnt;
    logic [DATA_W-1:0]      r_mem [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;

    logic w_req_s;
    logic w_edge;
    logic w_pop;
    logic w_space;
    logic w_bad;
    logic w_capture;
    logic w_push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_t};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_req_s ^ r_req_seen;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign w_space   = (r_count < 2'd2) | w_pop;

`ifdef TOGGLE_HS_RX_PARITY_EN
    logic r_par_err;

    assign w_bad   = ^{data_in, par_in};
    assign par_err = r_par_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (w_capture && w_bad) begin
            r_par_err <= 1'b1;
        end
    end
`else
    logic w_unused_par;

    assign w_unused_par = par_in;
    assign w_bad        = 1'b0;
    assign par_err      = 1'b0;
`endif

    // Bad-parity words are dropped but still acknowledged, so they never wait for space.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    if (w_space || w_bad) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!w_edge) begin
                    w_state_next = ST_IDLE;
                end else if (w_space || w_bad) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_push = w_capture & ~w_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_req_seen <= 1'b0;
            r_ack_t    <= 1'b0;
            r_xfer_cnt <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_ack_t    <= ~r_ack_t;
                r_req_seen <= w_req_s;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= ~r_wr_ptr;
                r_xfer_cnt      <= r_xfer_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ack_t    = r_ack_t;
    assign xfer_cnt = r_xfer_cnt;

endmodule

// File: doc/toggle_hs_rx.md
Name: toggle_hs_rx

Overview:
- Receiving end of the two-phase (toggle) request/acknowledge link driven by the team's T-flip-flop based senders.
- Sender toggles req_t once per word while holding data_in stable.
- This block synchronises req_t, detects each toggle, captures data_in into a 2-entry buffer, and answers with a toggle on ack_t.
- Buffered words go to the local consumer over a valid/ready interface.

Parameters:
- DATA_W, 8, width of data_in/out_data.
- SYNC_STAGES, 2, flops in the req_t synchroniser (legal 2..4).
- CNT_W, 16, width of xfer_cnt.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req_t  input  1  toggle request from sender; may be asynchronous to clk.
- data_in  input  DATA_W  sender data; stable from req_t toggle until ack_t toggle.
- par_in  input  1  even-parity bit over data_in; used only with the optional feature.
- ack_t  output  1  toggle acknowledge to sender.
- out_valid  output  1  buffer head valid.
- out_data  output  DATA_W  buffer head word.
- out_ready  input  1  consumer accepts head when out_valid=1.
- xfer_cnt  output  CNT_W  count of accepted words, wraps at 2^CNT_W.
- par_err  output  1  sticky parity error flag; optional feature only.

Behaviour:
- Reset (rst=0 at a rising edge):
  - sync chain=0, req_seen=0, ack_t=0, buffer empty, out_valid=0, out_data=0, xfer_cnt=0, par_err=0, state=IDLE.
  - Reset has priority over every other event.
  - Reset mid-transfer discards any pending toggle; the sender must be reset in the same cycle.
- Synchroniser:
  - req_t passes through SYNC_STAGES flops; req_s is the last stage.
  - edge = req_s XOR req_seen.
- FSM, 2 states:
  - IDLE: if edge and space → capture (below), stay IDLE. If edge and no space → HOLD.
  - HOLD: wait; when space → capture, go to IDLE.
  - space = (count<2) OR (out_valid AND out_ready) in the same cycle. Push and pop are allowed simultaneously when full.
- Capture, one clock: push data_in; ack_t<=~ack_t; req_seen<=req_s; xfer_cnt<=xfer_cnt+1.
- Latency: toggle of req_t sampled at edge k → ack_t toggles at edge k+SYNC_STAGES when space exists.
- Throughput: one word per sender round trip; no second capture until req_s toggles again.
- Buffer:
  - 2-entry FIFO; out_data shows the head; out_valid=(count!=0).
  - Pop when out_valid AND out_ready.
  - out_ready with empty buffer has no effect.
  - Simultaneous push+pop keeps count unchanged with order preserved.
- Sender protocol violation (second toggle before ack): not detected; an even number of toggles is invisible.
- xfer_cnt wraps 2^CNT_W-1 → 0 silently.

Optional Feature:
- Macro: TOGGLE_HS_RX_PARITY_EN.
- Defined:
  - At capture, compute XOR(data_in, par_in).
  - If 1: word is not pushed, xfer_cnt is not incremented, par_err<=1 (sticky until reset), ack_t still toggles so the link does not stall.
  - A parity-failed word needs no buffer space.
- Undefined: par_in ignored; par_err tied 0; all words pushed.

Test Plan:
- Reset: rst=0 for 2 clocks with req_t toggling → ack_t=0, out_valid=0, xfer_cnt=0 throughout.
- Single word: data_in=8'hA5, toggle req_t 0→1 → ack_t 0→1 exactly 2 clocks later. Next cycle out_valid=1, out_data=A5, xfer_cnt=1. out_ready=1 for one clock → out_valid=0.
- Back-pressure: out_ready=0; send 8'h11, 8'h22, 8'h33 → first two acked. Third toggle holds ack_t (state HOLD). Pulse out_ready one clock → pops 11, 33 captured and acked that cycle. Drain order is 22, 33.
- Simultaneous push/pop at full: buffer {44,55}, out_ready=1 at capture cycle of 66 → count stays 2, next head 55 then 66.
- Reset mid-op: in HOLD, assert rst → ack_t=0, buffer empty, no capture after release until a new toggle.
- With TOGGLE_HS_RX_PARITY_EN: data_in=8'h01, par_in=0 → ack_t toggles, par_err=1, out_valid stays 0, xfer_cnt unchanged. Then 8'h03, par_in=0 → accepted, par_err stays 1.
